// File: rtl/risc_pkg.sv
// Shared definitions for the RISC control path: opcodes, ALU function
// codes, branch condition codes and run-state encodings.
package risc_pkg;

  // Run-state encodings, also visible on the state output port
  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // Major opcodes, instr[15:11]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LHI   = 5'b00001;
  localparam logic [4:0] OP_LLI   = 5'b00010;
  localparam logic [4:0] OP_LDR   = 5'b00011;
  localparam logic [4:0] OP_STR   = 5'b00101;
  localparam logic [4:0] OP_ADDI  = 5'b00111;
  localparam logic [4:0] OP_SUBI  = 5'b01000;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_BCC   = 5'b11000;
  localparam logic [4:0] OP_OUTR  = 5'b11100;
  localparam logic [4:0] OP_HLT   = 5'b11111;

  // R-type function codes, instr[1:0]
  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_ADC = 2'b01;
  localparam logic [1:0] FN_SUB = 2'b10;
  localparam logic [1:0] FN_SBB = 2'b11;

  // Branch condition codes, instr[10:8]
  localparam logic [2:0] CC_EQ = 3'b000;
  localparam logic [2:0] CC_NE = 3'b001;
  localparam logic [2:0] CC_CS = 3'b010;
  localparam logic [2:0] CC_CC = 3'b011;
  localparam logic [2:0] CC_MI = 3'b100;
  localparam logic [2:0] CC_PL = 3'b101;
  localparam logic [2:0] CC_VS = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides whether a conditional branch is
// taken from the condition code and the latched architectural flags.
module cond_eval
  import risc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       c,
  input  logic       v,
  input  logic       z,
  input  logic       n,
  output logic       taken
);

  // Select and optionally invert the flag named by the condition code
  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = z;
      CC_NE:   taken = ~z;
      CC_CS:   taken = c;
      CC_CC:   taken = ~c;
      CC_MI:   taken = n;
      CC_PL:   taken = ~n;
      CC_VS:   taken = v;
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Control unit for the single-cycle datapath: LOAD/RUN/HALT sequencing,
// architectural flag register and zero-latency instruction decode.
module control_unit_fsm
  import risc_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IW  = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [IW-1:0] instr,
  input  logic          Pre_C,
  input  logic          Pre_V,
  input  logic          Pre_Z,
  input  logic          Pre_N,
  output logic          test_normal,
  output logic          flag_HLT,
  output logic          data_write_en,
  output logic          RF_write_en,
  output logic          flag_mem_RF,
  output logic          flag_ALU_RF,
  output logic          flag_Rm_RF,
  output logic          flag_PC_RF,
  output logic          LHI,
  output logic          LLI,
  output logic          flag_OutR,
  output logic          ADC,
  output logic          SUB,
  output logic          SBB,
  output logic          Src_ALU_B,
  output logic          Src_Read_B,
  output logic          JMP,
  output logic          BRANCH,
  output logic          flag_label_PC,
  output logic          flag_Rm_PC,
  output logic          flag_Rd_PC,
  output logic          C,
  output logic          V,
  output logic          Z,
  output logic          N,
  output logic [1:0]    state
);

  state_e          state_r;
  state_e          next_state_s;
  logic            c_r, v_r, z_r, n_r;
  logic            flag_we_s;
  logic            taken_s;
  logic [OPW-1:0]  opcode_s;
  logic [1:0]      funct_s;
  logic [5:0]      instr_unused_s;

  assign opcode_s       = instr[IW-1 -: OPW];
  assign funct_s        = instr[1:0];
  // Register/immediate fields are consumed by the datapath, not here
  assign instr_unused_s = instr[7:2];

  assign state = state_r;
  assign C     = c_r;
  assign V     = v_r;
  assign Z     = z_r;
  assign N     = n_r;

  cond_eval u_cond_eval (
    .cond  (instr[10:8]),
    .c     (c_r),
    .v     (v_r),
    .z     (z_r),
    .n     (n_r),
    .taken (taken_s)
  );

  // Run-state and flag register; clr dominates every other input
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_LOAD;
      c_r     <= 1'b0;
      v_r     <= 1'b0;
      z_r     <= 1'b0;
      n_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (flag_we_s) begin
        c_r <= Pre_C;
        v_r <= Pre_V;
        z_r <= Pre_Z;
        n_r <= Pre_N;
      end else begin
        c_r <= c_r;
        v_r <= v_r;
        z_r <= z_r;
        n_r <= n_r;
      end
    end
  end

  // Next-state, flag-write enable and datapath control decode
  always_comb begin
    next_state_s  = state_r;
    flag_we_s     = 1'b0;
    test_normal   = 1'b0;
    flag_HLT      = 1'b0;
    data_write_en = 1'b0;
    RF_write_en   = 1'b0;
    flag_mem_RF   = 1'b0;
    flag_ALU_RF   = 1'b0;
    flag_Rm_RF    = 1'b0;
    flag_PC_RF    = 1'b0;
    LHI           = 1'b0;
    LLI           = 1'b0;
    flag_OutR     = 1'b0;
    ADC           = 1'b0;
    SUB           = 1'b0;
    SBB           = 1'b0;
    Src_ALU_B     = 1'b0;
    Src_Read_B    = 1'b0;
    JMP           = 1'b0;
    BRANCH        = 1'b0;
    flag_label_PC = 1'b0;
    flag_Rm_PC    = 1'b0;
    flag_Rd_PC    = 1'b0;
    case (state_r)
      ST_LOAD: begin
        test_normal = 1'b1;
        if (start) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        flag_HLT     = 1'b1;
        next_state_s = ST_RUN;
        case (opcode_s)
          OP_RTYPE: begin
            flag_ALU_RF = 1'b1;
            RF_write_en = 1'b1;
            flag_we_s   = 1'b1;
            case (funct_s)
              FN_ADD:  ADC = 1'b0;
              FN_ADC:  ADC = 1'b1;
              FN_SUB:  SUB = 1'b1;
              FN_SBB:  SBB = 1'b1;
              default: ADC = 1'b0;
            endcase
          end
          OP_ADDI: begin
            Src_ALU_B   = 1'b1;
            flag_ALU_RF = 1'b1;
            RF_write_en = 1'b1;
            flag_we_s   = 1'b1;
          end
          OP_SUBI: begin
            Src_ALU_B   = 1'b1;
            flag_ALU_RF = 1'b1;
            RF_write_en = 1'b1;
            SUB         = 1'b1;
            flag_we_s   = 1'b1;
          end
          OP_LDR: begin
            Src_ALU_B   = 1'b1;
            flag_mem_RF = 1'b1;
            RF_write_en = 1'b1;
          end
          OP_STR: begin
            Src_ALU_B     = 1'b1;
            Src_Read_B    = 1'b1;
            data_write_en = 1'b1;
          end
          OP_LHI: begin
            LHI         = 1'b1;
            Src_Read_B  = 1'b1;
            RF_write_en = 1'b1;
          end
          OP_LLI: begin
            LLI         = 1'b1;
            RF_write_en = 1'b1;
          end
          OP_OUTR: flag_OutR = 1'b1;
          OP_JMP: begin
            JMP           = 1'b1;
            flag_label_PC = 1'b1;
          end
          OP_BCC: begin
            flag_label_PC = 1'b1;
            BRANCH        = taken_s;
          end
          OP_HLT: begin
            flag_HLT     = 1'b0;
            next_state_s = ST_HALT;
          end
          default: flag_HLT = 1'b1;
        endcase
      end
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_LOAD;
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed test-plan sequence
// with literal expectations, then randomized traffic against a
// behavioural model checked on every falling edge.
module tb_control_unit_fsm;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        pre_c = 1'b0, pre_v = 1'b0, pre_z = 1'b0, pre_n = 1'b0;
  logic        test_normal, flag_hlt, data_write_en, rf_write_en, flag_mem_rf;
  logic        flag_alu_rf, flag_rm_rf, flag_pc_rf, lhi, lli, flag_outr;
  logic        adc, sub, sbb, src_alu_b, src_read_b, jmp, branch;
  logic        flag_label_pc, flag_rm_pc, flag_rd_pc;
  logic        c_o, v_o, z_o, n_o;
  logic [1:0]  state_o;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  // Model state: 0 LOAD, 1 RUN, 2 HALT
  int m_state = 0;
  bit m_c = 1'b0, m_v = 1'b0, m_z = 1'b0, m_n = 1'b0;

  // Control vector bit masks (bench-side ordering)
  localparam logic [20:0] K_TN   = 21'd1 << 20;
  localparam logic [20:0] K_HLT  = 21'd1 << 19;
  localparam logic [20:0] K_DWE  = 21'd1 << 18;
  localparam logic [20:0] K_RFWE = 21'd1 << 17;
  localparam logic [20:0] K_MEM  = 21'd1 << 16;
  localparam logic [20:0] K_ALU  = 21'd1 << 15;
  localparam logic [20:0] K_LHI  = 21'd1 << 12;
  localparam logic [20:0] K_LLI  = 21'd1 << 11;
  localparam logic [20:0] K_OUT  = 21'd1 << 10;
  localparam logic [20:0] K_ADC  = 21'd1 << 9;
  localparam logic [20:0] K_SUB  = 21'd1 << 8;
  localparam logic [20:0] K_SBB  = 21'd1 << 7;
  localparam logic [20:0] K_SRCB = 21'd1 << 6;
  localparam logic [20:0] K_RDB  = 21'd1 << 5;
  localparam logic [20:0] K_JMP  = 21'd1 << 4;
  localparam logic [20:0] K_BR   = 21'd1 << 3;
  localparam logic [20:0] K_LBL  = 21'd1 << 2;

  control_unit_fsm dut (
    .clk(clk), .clr(clr), .start(start), .instr(instr),
    .Pre_C(pre_c), .Pre_V(pre_v), .Pre_Z(pre_z), .Pre_N(pre_n),
    .test_normal(test_normal), .flag_HLT(flag_hlt),
    .data_write_en(data_write_en), .RF_write_en(rf_write_en),
    .flag_mem_RF(flag_mem_rf), .flag_ALU_RF(flag_alu_rf),
    .flag_Rm_RF(flag_rm_rf), .flag_PC_RF(flag_pc_rf),
    .LHI(lhi), .LLI(lli), .flag_OutR(flag_outr),
    .ADC(adc), .SUB(sub), .SBB(sbb),
    .Src_ALU_B(src_alu_b), .Src_Read_B(src_read_b),
    .JMP(jmp), .BRANCH(branch), .flag_label_PC(flag_label_pc),
    .flag_Rm_PC(flag_rm_pc), .flag_Rd_PC(flag_rd_pc),
    .C(c_o), .V(v_o), .Z(z_o), .N(n_o), .state(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] dut_ctrl();
    return {test_normal, flag_hlt, data_write_en, rf_write_en, flag_mem_rf,
            flag_alu_rf, flag_rm_rf, flag_pc_rf, lhi, lli, flag_outr,
            adc, sub, sbb, src_alu_b, src_read_b, jmp, branch,
            flag_label_pc, flag_rm_pc, flag_rd_pc};
  endfunction

  // Expected controls from the instruction-set rules
  function automatic logic [20:0] exp_ctrl(int st, logic [15:0] ins,
                                           bit c, bit v, bit z, bit n);
    int op, fn, cc;
    bit [3:0] sel;
    bit tk;
    op = int'(ins[15:11]);
    fn = int'(ins[1:0]);
    cc = int'(ins[10:8]);
    if (st == 0) return K_TN;
    if (st == 2) return 21'd0;
    if (op == 31) return 21'd0;
    sel = {v, n, c, z};
    tk = (cc == 7) ? 1'b1 : (sel[cc / 2] ^ cc[0]);
    if (op == 0)  return K_HLT | K_ALU | K_RFWE | (fn == 1 ? K_ADC : 21'd0)
                         | (fn == 2 ? K_SUB : 21'd0) | (fn == 3 ? K_SBB : 21'd0);
    if (op == 7)  return K_HLT | K_SRCB | K_ALU | K_RFWE;
    if (op == 8)  return K_HLT | K_SRCB | K_ALU | K_RFWE | K_SUB;
    if (op == 3)  return K_HLT | K_SRCB | K_MEM | K_RFWE;
    if (op == 5)  return K_HLT | K_SRCB | K_RDB | K_DWE;
    if (op == 1)  return K_HLT | K_LHI | K_RDB | K_RFWE;
    if (op == 2)  return K_HLT | K_LLI | K_RFWE;
    if (op == 28) return K_HLT | K_OUT;
    if (op == 16) return K_HLT | K_JMP | K_LBL;
    if (op == 24) return K_HLT | K_LBL | (tk ? K_BR : 21'd0);
    return K_HLT;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model advance at each rising edge
  always @(posedge clk) begin
    int op;
    op = int'(instr[15:11]);
    if (clr) begin
      m_state = 0;
      {m_c, m_v, m_z, m_n} = 4'b0000;
    end else if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      if (op == 0 || op == 7 || op == 8) begin
        m_c = pre_c; m_v = pre_v; m_z = pre_z; m_n = pre_n;
      end
      if (op == 31) m_state = 2;
    end
  end

  // Compare DUT against model every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ctrl", 32'(dut_ctrl()),
            32'(exp_ctrl(m_state, instr, m_c, m_v, m_z, m_n)));
      check("model_state", 32'(state_o), 32'(m_state));
      check("model_flags", 32'({c_o, v_o, z_o, n_o}),
            32'({m_c, m_v, m_z, m_n}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic [15:0] i, bit s, bit r, bit [3:0] cvzn);
    instr = i; start = s; clr = r;
    {pre_c, pre_v, pre_z, pre_n} = cvzn;
    #1;
  endtask

  localparam logic [4:0] OPS [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd7,
                                     5'd8, 5'd16, 5'd24, 5'd28, 5'd31, 5'd18};

  initial begin
    // Reset / LOAD
    set_in(16'h0000, 1'b0, 1'b1, 4'b0000);
    step();
    chk_en = 1'b1;
    set_in(16'h0000, 1'b0, 1'b0, 4'b0000);
    check("load_state", 32'(state_o), 32'd0);
    check("load_ctrl", 32'(dut_ctrl()), 32'(K_TN));
    check("load_flags", 32'({c_o, v_o, z_o, n_o}), 32'd0);
    step();
    check("load_hold", 32'(state_o), 32'd0);
    set_in(16'h0000, 1'b1, 1'b0, 4'b0000);
    step();
    // Decode sweep in RUN
    set_in(16'h1900, 1'b0, 1'b0, 4'b0000);
    check("run_state", 32'(state_o), 32'd1);
    check("ldr_ctrl", 32'(dut_ctrl()), 32'h0B_0040);
    set_in(16'h4227, 1'b0, 1'b0, 4'b0000);
    check("subi_ctrl", 32'(dut_ctrl()), 32'h0A_8140);
    step();
    set_in(16'hE020, 1'b0, 1'b0, 4'b0000);
    check("outr_ctrl", 32'(dut_ctrl()), 32'h08_0400);
    step();
    // Flag latch: SUB with Pre_C=1, Pre_Z=1 (cvzn = 1010)
    set_in(16'h0346, 1'b0, 1'b0, 4'b1010);
    check("sub_ctrl", 32'(dut_ctrl()), 32'h0A_8100);
    step();
    set_in(16'hE020, 1'b0, 1'b0, 4'b0000);
    check("flags_after_sub", 32'({c_o, v_o, z_o, n_o}), 32'h0000_000A);
    step();
    check("z_held", 32'(z_o), 32'd1);
    // Branches
    set_in(16'hC005, 1'b0, 1'b0, 4'b0000);
    check("beq_ctrl", 32'(dut_ctrl()), 32'h08_000C);
    set_in(16'hC105, 1'b0, 1'b0, 4'b0000);
    check("bne_ctrl", 32'(dut_ctrl()), 32'h08_0004);
    set_in(16'hC705, 1'b0, 1'b0, 4'b0000);
    check("bal_ctrl", 32'(dut_ctrl()), 32'h08_000C);
    // Illegal opcode
    set_in(16'h9000, 1'b0, 1'b0, 4'b0000);
    check("nop_ctrl", 32'(dut_ctrl()), 32'(K_HLT));
    step();
    // Halt
    set_in(16'hFFFF, 1'b0, 1'b0, 4'b0000);
    check("hlt_ctrl", 32'(dut_ctrl()), 32'd0);
    step();
    set_in(16'h0000, 1'b1, 1'b0, 4'b1111);
    check("halt_state", 32'(state_o), 32'd2);
    check("halt_ctrl", 32'(dut_ctrl()), 32'd0);
    step();
    check("halt_ignores_start", 32'(state_o), 32'd2);
    check("halt_flags_held", 32'({c_o, v_o, z_o, n_o}), 32'h0000_000A);
    set_in(16'h0000, 1'b1, 1'b1, 4'b0000);
    step();
    check("clr_over_start", 32'(state_o), 32'd0);
    // Mid-run reset with flags set
    set_in(16'h0000, 1'b1, 1'b0, 4'b0000);
    step();
    set_in(16'h0000, 1'b0, 1'b0, 4'b1111);
    step();
    check("flags_all_set", 32'({c_o, v_o, z_o, n_o}), 32'h0000_000F);
    set_in(16'h0000, 1'b0, 1'b1, 4'b0000);
    step();
    check("midrun_clr_state", 32'(state_o), 32'd0);
    check("midrun_clr_flags", 32'({c_o, v_o, z_o, n_o}), 32'd0);

    // Randomized traffic checked by the model process
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      logic [10:0] rest;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : OPS[$urandom_range(0, 11)];
      if (op == 5'd31 && $urandom_range(0, 3) != 0) op = 5'd24;
      rest = 11'($urandom);
      set_in({op, rest}, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
             4'($urandom));
      step();
    end
    clr = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
